// File: rtl/mv_decim_out.sv
// Decimating output stage for the moving-average filter: offset, shift,
// saturate and hand off one word at a time over valid/ready.
module mv_decim_out #(
  parameter int WARMUP_CYCLES = 8194,
  parameter int DECIM_W       = 16,
  parameter int OUT_W         = 24
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic [31:0]        din,
  input  logic [DECIM_W-1:0] decim,
  input  logic [31:0]        offset,
  input  logic [4:0]         shift,
  output logic [OUT_W-1:0]   dout,
  output logic               dout_sat,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [15:0]        overrun_cnt,
  output logic               running
);

  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic signed [32:0] HI = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] LO = -(33'sd1 <<< (OUT_W - 1));

  logic [0:0]         state_q, state_d;
  logic [WW-1:0]      warm_q, warm_d;
  logic [DECIM_W-1:0] cnt_q, cnt_d;
  logic               s1_valid_q, s1_valid_d;
  logic signed [32:0] diff_q, diff_d;
  logic               s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic               res_sat_q, res_sat_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic               dout_sat_q, dout_sat_d;
  logic               dout_valid_q, dout_valid_d;
  logic [15:0]        ovr_q, ovr_d;

  logic [DECIM_W-1:0] neff_m1;
  logic               tick;
  logic signed [32:0] sh;
  logic [OUT_W-1:0]   clip_val;
  logic               clip_sat;

  // decim==0 behaves as 1, so the threshold is 0 in both cases
  assign neff_m1 = (decim == '0) ? '0 : decim - DECIM_W'(1);
  assign tick    = (state_q == ST_RUN) && (cnt_q >= neff_m1);
  assign sh      = diff_q >>> shift;

  always_comb begin
    clip_val = sh[OUT_W-1:0];
    clip_sat = 1'b0;
    if (sh > HI) begin
      clip_val = HI[OUT_W-1:0];
      clip_sat = 1'b1;
    end else if (sh < LO) begin
      clip_val = LO[OUT_W-1:0];
      clip_sat = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    cnt_d        = cnt_q;
    s1_valid_d   = tick;
    diff_d       = diff_q;
    s2_valid_d   = s1_valid_q;
    res_d        = res_q;
    res_sat_d    = res_sat_q;
    dout_d       = dout_q;
    dout_sat_d   = dout_sat_q;
    dout_valid_d = dout_valid_q;
    ovr_d        = ovr_q;

    if (state_q == ST_WARMUP) begin
      warm_d = warm_q + WW'(1);
      cnt_d  = '0;
      if (warm_q == WARM_LAST) state_d = ST_RUN;
    end else begin
      cnt_d = tick ? '0 : cnt_q + DECIM_W'(1);
    end

    if (tick) diff_d = {din[31], din} - {offset[31], offset};

    if (s1_valid_q) begin
      res_d     = clip_val;
      res_sat_d = clip_sat;
    end

    // a held word is never overwritten; late results are counted and dropped
    if (s2_valid_q) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = res_q;
        dout_sat_d   = res_sat_q;
        dout_valid_d = 1'b1;
      end else if (ovr_q != 16'hFFFF) begin
        ovr_d = ovr_q + 16'd1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    if (clr) begin
      state_d      = ST_WARMUP;
      warm_d       = '0;
      cnt_d        = '0;
      s1_valid_d   = 1'b0;
      s2_valid_d   = 1'b0;
      dout_d       = '0;
      dout_sat_d   = 1'b0;
      dout_valid_d = 1'b0;
      ovr_d        = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_WARMUP;
      warm_q       <= '0;
      cnt_q        <= '0;
      s1_valid_q   <= 1'b0;
      diff_q       <= '0;
      s2_valid_q   <= 1'b0;
      res_q        <= '0;
      res_sat_q    <= 1'b0;
      dout_q       <= '0;
      dout_sat_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      cnt_q        <= cnt_d;
      s1_valid_q   <= s1_valid_d;
      diff_q       <= diff_d;
      s2_valid_q   <= s2_valid_d;
      res_q        <= res_d;
      res_sat_q    <= res_sat_d;
      dout_q       <= dout_d;
      dout_sat_q   <= dout_sat_d;
      dout_valid_q <= dout_valid_d;
      ovr_q        <= ovr_d;
    end
  end

  assign dout        = dout_q;
  assign dout_sat    = dout_sat_q;
  assign dout_valid  = dout_valid_q;
  assign overrun_cnt = ovr_q;
  assign running     = (state_q == ST_RUN);

endmodule

// File: tb/tb_mv_decim_out.sv
// Bench for mv_decim_out: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_mv_decim_out;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clr;
  logic [31:0] din;
  logic [15:0] decim;
  logic [31:0] offset;
  logic [4:0]  shift;
  logic [23:0] dout;
  logic        dout_sat;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] overrun_cnt;
  logic        running;

  mv_decim_out #(
    .WARMUP_CYCLES(W),
    .DECIM_W(16),
    .OUT_W(24)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .clr(clr),
    .din(din),
    .decim(decim),
    .offset(offset),
    .shift(shift),
    .dout(dout),
    .dout_sat(dout_sat),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun_cnt(overrun_cnt),
    .running(running)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  bit          m_run;
  int          m_edges;
  int          m_ph;
  bit          m_s1v;
  longint      m_s1d;
  bit          m_s2v;
  logic [23:0] m_s2r;
  bit          m_s2s;
  bit          m_v;
  logic [23:0] m_dout;
  bit          m_sat;
  int          m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_edges = 0; m_ph = 0;
    m_s1v = 0; m_s1d = 0; m_s2v = 0;
    m_s2r = '0; m_s2s = 0;
    m_v = 0; m_dout = '0; m_sat = 0; m_ovr = 0;
  endtask

  // floor(d / 2^sh), then clip to the signed 24-bit range
  task automatic scale(input longint d, input int s,
                       output logic [23:0] v, output bit sat);
    longint p, q, hi, lo;
    p  = longint'(1) << s;
    q  = (d >= 0) ? d / p : -((-d + p - 1) / p);
    hi = (longint'(1) << 23) - 1;
    lo = -(longint'(1) << 23);
    sat = 0;
    if (q > hi) begin q = hi; sat = 1; end
    if (q < lo) begin q = lo; sat = 1; end
    v = q[23:0];
  endtask

  task automatic model_edge();
    int  neff;
    bit  tk;
    logic [23:0] v;
    bit  s;
    if (clr) begin
      model_reset();
      return;
    end
    neff = (decim == 0) ? 1 : int'(decim);
    tk = m_run && (m_ph >= neff - 1);
    if (m_s2v) begin
      if (!m_v || dout_ready) begin
        m_dout = m_s2r; m_sat = m_s2s; m_v = 1;
      end else if (m_ovr < 65535) begin
        m_ovr++;
      end
    end else if (m_v && dout_ready) begin
      m_v = 0;
    end
    m_s2v = m_s1v;
    if (m_s1v) begin
      scale(m_s1d, int'(shift), v, s);
      m_s2r = v; m_s2s = s;
    end
    m_s1v = tk;
    if (tk) m_s1d = longint'($signed(din)) - longint'($signed(offset));
    if (tk) m_ph = 0;
    else if (m_run) m_ph++;
    else m_ph = 0;
    if (!m_run) begin
      m_edges++;
      if (m_edges >= W) m_run = 1;
    end
  endtask

  task automatic cmp_all();
    chk("valid", dout_valid, m_v);
    chk("dout", dout, m_dout);
    chk("sat", dout_sat, m_sat);
    chk("ovr", overrun_cnt, m_ovr);
    chk("running", running, m_run);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_all();
  endtask

  task automatic async_reset();
    #2 n_rst = 1'b0;
    #1 model_reset();
    cmp_all();
    @(negedge clk) n_rst = 1'b1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int e;
    int k;
    n_rst = 1'b0; clr = 1'b0;
    din = 32'd1000; decim = 16'd4; offset = '0; shift = '0;
    dout_ready = 1'b1;
    #1 model_reset();
    cmp_all();
    @(negedge clk) n_rst = 1'b1;

    // warmup then first decimated word
    e = 0;
    while (!dout_valid && e < 40) begin
      step();
      e++;
      if (e == W) chk("t1_run", running, 1);
    end
    chk("t1_first", e, 22);
    chk("t1_dout", dout, 1000);
    repeat (12) step();

    // offset and shift
    decim = 16'd1; din = -32'sd1000; offset = 32'd100; shift = 5'd2;
    repeat (3) step();
    chk("t2_dout", dout, 24'hFFFEED);
    chk("t2_sat", dout_sat, 0);

    din = 32'h7FFFFFFF; offset = 32'hFFFFFFFF; shift = 5'd0;
    repeat (3) step();
    chk("t3a_dout", dout, 24'h7FFFFF);
    chk("t3a_sat", dout_sat, 1);
    din = 32'h80000000; offset = 32'd1;
    repeat (3) step();
    chk("t3b_dout", dout, 24'h800000);
    chk("t3b_sat", dout_sat, 1);
    din = 32'h7FFFFFFF; offset = 32'd0; shift = 5'd8;
    repeat (3) step();
    chk("t3c_dout", dout, 24'h7FFFFF);
    chk("t3c_sat", dout_sat, 0);

    // backpressure
    clr_pulse();
    decim = 16'd2; din = 32'd77; offset = '0; shift = '0;
    e = 0;
    while (!dout_valid && e < 60) begin
      step();
      e++;
    end
    chk("t4_wait", dout_valid, 1);
    dout_ready = 1'b0;
    din = 32'd555;
    repeat (20) step();
    chk("t4_ovr", overrun_cnt, 10);
    chk("t4_hold", dout, 77);
    dout_ready = 1'b1;
    repeat (6) step();

    // decimation ratio change mid-count
    clr_pulse();
    decim = 16'd8;
    e = 0;
    while (!dout_valid && e < 60) begin
      step();
      e++;
    end
    repeat (3) step();
    decim = 16'd2;
    k = 0;
    while (!dout_valid && k < 10) begin
      step();
      k++;
    end
    chk("t5_lat", k, 3);
    repeat (6) step();
    decim = 16'd0;
    repeat (6) step();

    // async reset and clr while a word is held
    dout_ready = 1'b0;
    repeat (2) step();
    async_reset();
    chk("t6_valid", dout_valid, 0);
    repeat (W + 6) step();
    clr_pulse();
    chk("t6_clr", dout_valid, 0);
    repeat (4) step();

    // random traffic
    dout_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: din = 32'h7FFFFFFF;
        1: din = 32'h80000000;
        2: din = $urandom_range(0, 4000) - 2000;
        default: din = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) offset = $urandom;
      if ($urandom_range(0, 15) == 0) shift = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) decim = 16'($urandom_range(0, 5));
      dout_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 299) == 0);
      step();
      clr = 1'b0;
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
